test_sequencer: RTL and testbench

Synthesizable, parametrised self-checking test controller for the MIPS core. It runs NUM_TESTS tests back to back: it resets the DUT, schedules interrupt pulses per channel, and watches memwrite/dataadr/writedata against a per-test expected store. It reports a pass/fail result per test and a final pass count. It sits beside `top` in FPGA/emulation builds and is driven from a table of expected values.

---
 rtl/test_seq_pkg.sv | 16 +
 rtl/irq_pulse_gen.sv | 79 +++++++
 rtl/test_sequencer.sv | 163 ++++++++++++++++
 tb/tb_test_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_seq_pkg.sv
// Shared types and field helpers for the MIPS test sequencer and its interrupt generators.
package test_seq_pkg;

  typedef enum logic [2:0] {IDLE, RST, RUN, REPORT, DONE} state_t;
  typedef enum logic [1:0] {P_WAIT, P_HIGH, P_LOW, P_END} irq_phase_t;

  localparam int LEN_W  = 8;
  localparam int GAP_W  = 8;
  localparam int REPS_W = 4;

  // Channel fields are packed channel 0 in the least significant slot.
  function automatic int field_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/irq_pulse_gen.sv
// One interrupt channel: waits for cyc==start, then emits reps pulses of len
// high cycles separated by gap low cycles. Silent when len or reps is zero.
module irq_pulse_gen
  import test_seq_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              run,
  input  logic [CW-1:0]     cyc,
  input  logic [CW-1:0]     start,
  input  logic [LEN_W-1:0]  len,
  input  logic [GAP_W-1:0]  gap,
  input  logic [REPS_W-1:0] reps,
  output logic              irq
);

  irq_phase_t        phase;
  logic [LEN_W-1:0]  cnt;
  logic [REPS_W-1:0] left;
  logic              enabled;
  logic [CW-1:0]     cyc_next;

  assign enabled  = (len != '0) && (reps != '0);
  assign cyc_next = cyc + 1'b1;
  assign irq      = run && (phase == P_HIGH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      phase <= P_WAIT;
      cnt   <= '0;
      left  <= '0;
    end else if (!run) begin
      // Preload outside RUN so start==0 is already high on the first RUN cycle.
      phase <= (enabled && start == '0) ? P_HIGH : P_WAIT;
      cnt   <= len;
      left  <= reps;
    end else begin
      case (phase)
        P_WAIT: begin
          if (enabled && cyc_next == start) begin
            phase <= P_HIGH;
            cnt   <= len;
          end
        end
        P_HIGH: begin
          if (cnt == LEN_W'(1)) begin
            if (left == REPS_W'(1)) begin
              phase <= P_END;
            end else begin
              left <= left - 1'b1;
              if (gap == '0) begin
                cnt <= len;
              end else begin
                phase <= P_LOW;
                cnt   <= gap;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        P_LOW: begin
          if (cnt == LEN_W'(1)) begin
            phase <= P_HIGH;
            cnt   <= len;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: phase <= P_END;
      endcase
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Self-checking test controller for the MIPS core: resets the DUT, drives interrupts,
// scores stores per test. Define TEST_SEQ_WDOG_EN to build the idle-write watchdog.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int NUM_TESTS    = 24,
  parameter int NUM_IRQ      = 8,
  parameter int CW           = 32,
  parameter int RESET_CYCLES = 3,
  parameter int IW           = $clog2(NUM_TESTS)
`ifdef TEST_SEQ_WDOG_EN
  ,
  parameter int WDOG_CYCLES  = 1024
`endif
) (
  input  logic                      ph1,
  input  logic                      reset,
  input  logic                      start,
  output logic [IW-1:0]             test_idx,
  input  logic [31:0]               exp_adr,
  input  logic [31:0]               exp_data,
  input  logic                      exp_adr_care,
  input  logic                      exp_strict,
  input  logic                      exp_early,
  input  logic [CW-1:0]             exp_budget,
  input  logic [NUM_IRQ*CW-1:0]     irq_start,
  input  logic [NUM_IRQ*LEN_W-1:0]  irq_len,
  input  logic [NUM_IRQ*GAP_W-1:0]  irq_gap,
  input  logic [NUM_IRQ*REPS_W-1:0] irq_reps,
  input  logic                      memwrite,
  input  logic [31:0]               dataadr,
  input  logic [31:0]               writedata,
  output logic                      dut_reset,
  output logic [NUM_IRQ-1:0]        interrupts,
  output logic                      result_valid,
  output logic                      result_pass,
  output logic                      result_timeout,
  output logic [IW-1:0]             result_idx,
  output logic [CW-1:0]             result_cycles,
  output logic [IW:0]               pass_count,
  output logic                      busy,
  output logic                      done
);

  state_t        state;
  logic [CW-1:0] cyc;
  logic [CW-1:0] rst_cnt;
  logic [CW-1:0] budget_last;
  logic          hit, miss;
  logic          run, match, hit_now, miss_now;
  logic          run_end, test_pass, wdog_trip;

  assign run         = (state == RUN);
  assign dut_reset   = !run;
  assign match       = memwrite && (writedata == exp_data) &&
                       (!exp_adr_care || dataadr == exp_adr);
  assign hit_now     = hit || match;
  assign miss_now    = miss || (memwrite && !match && exp_strict);
  // A zero budget still gets one RUN cycle.
  assign budget_last = (exp_budget == '0) ? '0 : exp_budget - 1'b1;
  assign run_end     = (cyc == budget_last) || (exp_early && match) || wdog_trip;
  assign test_pass   = hit_now && !miss_now && !wdog_trip;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cyc           <= '0;
      rst_cnt       <= '0;
      hit           <= 1'b0;
      miss          <= 1'b0;
      test_idx      <= '0;
      pass_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_valid  <= 1'b0;
      result_pass   <= 1'b0;
      result_idx    <= '0;
      result_cycles <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RST;
            rst_cnt    <= '0;
            test_idx   <= '0;
            pass_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RST: begin
          hit  <= 1'b0;
          miss <= 1'b0;
          cyc  <= '0;
          if (rst_cnt == CW'(RESET_CYCLES - 1)) state <= RUN;
          else                                  rst_cnt <= rst_cnt + 1'b1;
        end
        RUN: begin
          hit  <= hit_now;
          miss <= miss_now;
          if (run_end) begin
            state         <= REPORT;
            result_valid  <= 1'b1;
            result_pass   <= test_pass;
            result_idx    <= test_idx;
            result_cycles <= cyc + 1'b1;
            if (test_pass) pass_count <= pass_count + 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        REPORT: begin
          if (test_idx == IW'(NUM_TESTS - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= RST;
            rst_cnt  <= '0;
            test_idx <= test_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TEST_SEQ_WDOG_EN
  logic [CW-1:0] idle;

  assign wdog_trip = run && !memwrite && (idle == CW'(WDOG_CYCLES - 1));

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      idle           <= '0;
      result_timeout <= 1'b0;
    end else begin
      if (!run || memwrite) idle <= '0;
      else                  idle <= idle + 1'b1;
      if (run && run_end) result_timeout <= wdog_trip;
    end
  end
`else
  assign wdog_trip      = 1'b0;
  assign result_timeout = 1'b0;
`endif

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_irq
    irq_pulse_gen #(.CW(CW)) u_gen (
      .ph1   (ph1),
      .reset (reset),
      .run   (run),
      .cyc   (cyc),
      .start (irq_start[field_lsb(i, CW) +: CW]),
      .len   (irq_len[field_lsb(i, LEN_W) +: LEN_W]),
      .gap   (irq_gap[field_lsb(i, GAP_W) +: GAP_W]),
      .reps  (irq_reps[field_lsb(i, REPS_W) +: REPS_W]),
      .irq   (interrupts[i])
    );
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench for test_sequencer: three-test table, a behavioural store model,
// interrupt waveform checks and a mid-test reset abort.
module tb_test_sequencer;

  localparam int NT = 3;
  localparam int NI = 2;
  localparam int CW = 32;
  localparam int IW = 2;

  logic           ph1 = 1'b0;
  logic           reset, start;
  logic [IW-1:0]  test_idx;
  logic [31:0]    exp_adr, exp_data;
  logic           exp_adr_care, exp_strict, exp_early;
  logic [CW-1:0]  exp_budget;
  logic [NI*CW-1:0] irq_start;
  logic [NI*8-1:0]  irq_len, irq_gap;
  logic [NI*4-1:0]  irq_reps;
  logic           memwrite;
  logic [31:0]    dataadr, writedata;
  logic           dut_reset;
  logic [NI-1:0]  interrupts;
  logic           result_valid, result_pass, result_timeout;
  logic [IW-1:0]  result_idx;
  logic [CW-1:0]  result_cycles;
  logic [IW:0]    pass_count;
  logic           busy, done;

  // Expected-value table, addressed by the sequencer's test_idx.
  logic [31:0] t_adr[4], t_data[4], t_budget[4];
  logic        t_care[4], t_strict[4], t_early[4];
  int          w_cyc[4][2];
  logic [31:0] w_adr[4][2], w_dat[4][2];

  assign exp_adr      = t_adr[test_idx];
  assign exp_data     = t_data[test_idx];
  assign exp_adr_care = t_care[test_idx];
  assign exp_strict   = t_strict[test_idx];
  assign exp_early    = t_early[test_idx];
  assign exp_budget   = t_budget[test_idx];

  int total, bad;
  int nres, first_run;
  int r_idx[8], r_pass[8], r_cyc[8], r_pc[8], r_to[8];
  bit irq_hi[NI][600];

  test_sequencer #(.NUM_TESTS(NT), .NUM_IRQ(NI), .CW(CW), .RESET_CYCLES(3), .IW(IW)) dut (
    .ph1(ph1), .reset(reset), .start(start), .test_idx(test_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_adr_care(exp_adr_care),
    .exp_strict(exp_strict), .exp_early(exp_early), .exp_budget(exp_budget),
    .irq_start(irq_start), .irq_len(irq_len), .irq_gap(irq_gap), .irq_reps(irq_reps),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .dut_reset(dut_reset), .interrupts(interrupts),
    .result_valid(result_valid), .result_pass(result_pass), .result_timeout(result_timeout),
    .result_idx(result_idx), .result_cycles(result_cycles), .pass_count(pass_count),
    .busy(busy), .done(done)
  );

  always #5 ph1 = ~ph1;

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  task automatic set_test(input int t, input logic [31:0] adr, input logic [31:0] data,
                          input logic care, input logic strict, input logic early,
                          input logic [31:0] budget,
                          input int wc0, input logic [31:0] wa0, input logic [31:0] wd0,
                          input int wc1, input logic [31:0] wa1, input logic [31:0] wd1);
    t_adr[t] = adr; t_data[t] = data; t_care[t] = care; t_strict[t] = strict;
    t_early[t] = early; t_budget[t] = budget;
    w_cyc[t][0] = wc0; w_adr[t][0] = wa0; w_dat[t][0] = wd0;
    w_cyc[t][1] = wc1; w_adr[t][1] = wa1; w_dat[t][1] = wd1;
  endtask

  task automatic set_irq(input int ch, input int st, input int len, input int gap, input int reps);
    irq_start[ch*CW +: CW] = st;
    irq_len[ch*8 +: 8]     = len[7:0];
    irq_gap[ch*8 +: 8]     = gap[7:0];
    irq_reps[ch*4 +: 4]    = reps[3:0];
  endtask

  // Pulses start, then models the DUT's stores cycle by cycle and logs results.
  // abort_at >= 0 returns at that RUN cycle of test 1 without waiting for done.
  task automatic run_seq(input int max_cycles, input int extra_start_at, input int abort_at);
    int rc;
    int t;
    nres = 0; first_run = -1; rc = -1;
    for (int i = 0; i < 8; i++) begin
      r_idx[i] = -1; r_pass[i] = -1; r_cyc[i] = -1; r_pc[i] = -1; r_to[i] = -1;
    end
    for (int c = 0; c < NI; c++) for (int k = 0; k < 600; k++) irq_hi[c][k] = 1'b0;
    @(negedge ph1); start = 1'b1;
    @(negedge ph1); start = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      if (done) break;
      if (result_valid && nres < 8) begin
        r_idx[nres] = int'(result_idx);   r_pass[nres] = int'(result_pass);
        r_cyc[nres] = int'(result_cycles); r_pc[nres] = int'(pass_count);
        r_to[nres]  = int'(result_timeout);
        nres++;
      end
      if (dut_reset) rc = -1;
      else           rc++;
      if (!dut_reset && first_run < 0) first_run = n;
      t = int'(test_idx);
      if (abort_at >= 0 && t == 1 && rc == abort_at) return;
      if (t == 0 && rc >= 0 && rc < 600)
        for (int c = 0; c < NI; c++) irq_hi[c][rc] = interrupts[c];
      memwrite = 1'b0; dataadr = 32'hdead_0000; writedata = 32'h0;
      for (int k = 0; k < 2; k++)
        if (rc >= 0 && rc == w_cyc[t][k]) begin
          memwrite = 1'b1; dataadr = w_adr[t][k]; writedata = w_dat[t][k];
        end
      start = (n == extra_start_at);
      @(negedge ph1);
    end
    memwrite = 1'b0; start = 1'b0;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL seq_done: done=%0b required 1 within %0d cycles", done, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (3) @(negedge ph1);
    total++;
    if ({dut_reset, interrupts, result_valid, result_pass, result_timeout, busy, done} !== 8'b1_00_000_00) begin
      bad++; $display("FAIL reset_flags: got %b want 10000000",
                      {dut_reset, interrupts, result_valid, result_pass, result_timeout, busy, done});
    end
    total++;
    if ({test_idx, result_idx, result_cycles, pass_count} !== '0) begin
      bad++; $display("FAIL reset_values: idx=%0d ridx=%0d rcyc=%0d pc=%0d want all 0",
                      test_idx, result_idx, result_cycles, pass_count);
    end
    reset = 1'b0;
    repeat (2) @(negedge ph1);
    total++;
    if ({dut_reset, busy} !== 2'b10) begin
      bad++; $display("FAIL idle_hold: dut_reset,busy=%b want 10", {dut_reset, busy});
    end
  endtask

  task automatic test_basic();
    int e_cyc[3] = '{500, 101, 31};
    int errs[NI];
    int first_bad[NI];
    bit want;
    for (int t = 0; t < 3; t++)
      set_test(t, 32'h14, 32'd21, 1'b1, 1'b0, t != 0, 32'd500,
               (t == 2) ? 30 : 100, 32'h14, 32'd21, -1, 0, 0);
    set_irq(0, 10, 3, 4, 0);
    set_irq(1, 50, 5, 90, 2);
    // A second start during test 0 must be ignored.
    run_seq(3000, 200, -1);
    total++;
    if (busy !== 1'b0 || pass_count !== 3) begin
      bad++; $display("FAIL basic_final: busy=%0b pc=%0d want busy=0 pc=3", busy, pass_count);
    end
    total++;
    if (first_run !== 3) begin
      bad++; $display("FAIL basic_rst_len: first RUN at %0d want 3", first_run);
    end
    total++;
    if (nres !== 3) begin bad++; $display("FAIL basic_nres: got %0d want 3", nres); end
    for (int i = 0; i < 3; i++) begin
      total += 5;
      if (r_idx[i] !== i)        begin bad++; $display("FAIL basic_idx[%0d]: got %0d want %0d", i, r_idx[i], i); end
      if (r_pass[i] !== 1)       begin bad++; $display("FAIL basic_pass[%0d]: got %0d want 1", i, r_pass[i]); end
      if (r_cyc[i] !== e_cyc[i]) begin bad++; $display("FAIL basic_cycles[%0d]: got %0d want %0d", i, r_cyc[i], e_cyc[i]); end
      if (r_pc[i] !== i + 1)     begin bad++; $display("FAIL basic_pc[%0d]: got %0d want %0d", i, r_pc[i], i + 1); end
      if (r_to[i] !== 0)         begin bad++; $display("FAIL basic_timeout[%0d]: got %0d want 0", i, r_to[i]); end
    end
    // Channel 1: high 50..54, low for 90 cycles, high again 145..149. Channel 0 has reps=0.
    for (int c = 0; c < NI; c++) begin
      errs[c] = 0; first_bad[c] = -1;
      for (int k = 0; k < 500; k++) begin
        want = (c == 1) && ((k >= 50 && k <= 54) || (k >= 145 && k <= 149));
        if (irq_hi[c][k] !== want) begin
          errs[c]++;
          if (first_bad[c] < 0) first_bad[c] = k;
        end
      end
      total++;
      if (errs[c] !== 0) begin
        bad++; $display("FAIL basic_irq%0d: %0d wrong cycles, first at %0d (got %0b)",
                        c, errs[c], first_bad[c], irq_hi[c][first_bad[c]]);
      end
    end
  endtask

  task automatic test_strict_and_care();
    int e_pass[3] = '{0, 1, 1};
    int e_cyc[3]  = '{100, 100, 11};
    int e_pc[3]   = '{0, 1, 2};
    int errs;
    bit want;
    set_test(0, 32'h14, 32'd21, 1'b1, 1'b1, 1'b0, 32'd100, 20, 32'h10, 32'd5, 40, 32'h14, 32'd21);
    set_test(1, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd100, 20, 32'h10, 32'd5, 40, 32'h14, 32'd21);
    set_test(2, 32'h14, 32'd479001600, 1'b0, 1'b0, 1'b1, 32'd50, 10, 32'h3c, 32'd479001600, -1, 0, 0);
    set_irq(0, 0, 0, 2, 3);
    set_irq(1, 0, 2, 3, 2);
    run_seq(2000, -1, -1);
    total++;
    if (nres !== 3 || pass_count !== 2) begin
      bad++; $display("FAIL strict_summary: nres=%0d pc=%0d want 3 and 2", nres, pass_count);
    end
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (r_pass[i] !== e_pass[i]) begin bad++; $display("FAIL strict_pass[%0d]: got %0d want %0d", i, r_pass[i], e_pass[i]); end
      if (r_cyc[i] !== e_cyc[i])   begin bad++; $display("FAIL strict_cycles[%0d]: got %0d want %0d", i, r_cyc[i], e_cyc[i]); end
      if (r_pc[i] !== e_pc[i])     begin bad++; $display("FAIL strict_pc[%0d]: got %0d want %0d", i, r_pc[i], e_pc[i]); end
    end
    // Channel 1 starts on RUN cycle 0: high 0-1 and 5-6. Channel 0 has len=0.
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      want = (k <= 1) || (k == 5) || (k == 6);
      if (irq_hi[1][k] !== want || irq_hi[0][k] !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL strict_irq: %0d wrong cycles want 0", errs); end
  endtask

  task automatic test_nomatch_budget();
    int e_pass[3] = '{0, 0, 1};
    int e_cyc[3]  = '{60, 1, 20};
    int e_pc[3]   = '{0, 0, 1};
    set_test(0, 32'h14, 32'd479001600, 1'b0, 1'b0, 1'b0, 32'd60, 5, 32'h3c, 32'd479001599, -1, 0, 0);
    set_test(1, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd0, -1, 0, 0, -1, 0, 0);
    set_test(2, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd20, 5, 32'h18, 32'd21, 19, 32'h14, 32'd21);
    set_irq(0, 0, 0, 0, 0);
    set_irq(1, 0, 0, 0, 0);
    run_seq(2000, -1, -1);
    total++;
    if (nres !== 3) begin bad++; $display("FAIL nomatch_nres: got %0d want 3", nres); end
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (r_pass[i] !== e_pass[i]) begin bad++; $display("FAIL nomatch_pass[%0d]: got %0d want %0d", i, r_pass[i], e_pass[i]); end
      if (r_cyc[i] !== e_cyc[i])   begin bad++; $display("FAIL nomatch_cycles[%0d]: got %0d want %0d", i, r_cyc[i], e_cyc[i]); end
      if (r_pc[i] !== e_pc[i])     begin bad++; $display("FAIL nomatch_pc[%0d]: got %0d want %0d", i, r_pc[i], e_pc[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    for (int t = 0; t < 3; t++)
      set_test(t, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd500, (t == 0) ? 100 : -1, 32'h14, 32'd21, -1, 0, 0);
    set_irq(0, 0, 0, 0, 0);
    set_irq(1, 0, 200, 1, 1);
    run_seq(2000, -1, 20);
    total++;
    if (interrupts !== 2'b10 || pass_count !== 1 || test_idx !== 1) begin
      bad++; $display("FAIL abort_pre: irq=%b pc=%0d idx=%0d want irq=10 pc=1 idx=1",
                      interrupts, pass_count, test_idx);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({dut_reset, busy, done, result_valid, result_pass, interrupts} !== 7'b1_0000_00) begin
      bad++; $display("FAIL abort_flags: got %b want 1000000",
                      {dut_reset, busy, done, result_valid, result_pass, interrupts});
    end
    total++;
    if ({pass_count, test_idx, result_idx, result_cycles} !== '0) begin
      bad++; $display("FAIL abort_values: pc=%0d idx=%0d ridx=%0d rcyc=%0d want all 0",
                      pass_count, test_idx, result_idx, result_cycles);
    end
    repeat (2) @(negedge ph1);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge ph1);
      if (result_valid || !dut_reset || busy) n++;
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL abort_quiet: %0d active cycles after abort want 0", n); end
  endtask

`ifdef TEST_SEQ_WDOG_EN
  task automatic test_wdog();
    set_test(0, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd2000, -1, 0, 0, -1, 0, 0);
    set_test(1, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd10, -1, 0, 0, -1, 0, 0);
    set_test(2, 32'h14, 32'd21, 1'b1, 1'b0, 1'b0, 32'd10, -1, 0, 0, -1, 0, 0);
    run_seq(4000, -1, -1);
    total++;
    if (r_cyc[0] !== 1024 || r_to[0] !== 1 || r_pass[0] !== 0) begin
      bad++; $display("FAIL wdog: cycles=%0d timeout=%0d pass=%0d want 1024 1 0", r_cyc[0], r_to[0], r_pass[0]);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    for (int t = 0; t < 4; t++) set_test(t, 0, 0, 1'b0, 1'b0, 1'b0, 32'd1, -1, 0, 0, -1, 0, 0);
    for (int c = 0; c < NI; c++) set_irq(c, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_strict_and_care();
    test_nomatch_budget();
    test_reset_abort();
`ifdef TEST_SEQ_WDOG_EN
    test_wdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
